// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized RO rising edges in a clk gate.
// Define RO_FREQ_AVG_EN to average four back-to-back passes per start.
module ro_freq_meter #(
    parameter int SETTLE_CYCLES = 4,
    parameter int GATE_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ro_clk_in,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int TMAX = (SETTLE_CYCLES > GATE_CYCLES) ?
                          SETTLE_CYCLES : GATE_CYCLES;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [TW-1:0]    tmr;
    logic             settle_end;
    logic             gate_end;
    logic             last_pass;
    logic             meas_entry;
    logic             done_entry;
    logic             ro_en_nx;

    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             rise;

    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] wcnt_nx;
    logic             wovf;
    logic             wovf_nx;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort wins over any phase-end transition
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (settle_end) begin
                    state_nx = MEASURE;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (gate_end) begin
                    state_nx = last_pass ? DONE : SETTLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        ro_en_nx = (state_nx == SETTLE) || (state_nx == MEASURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_en <= 1'b0;
        end else begin
            ro_en <= ro_en_nx;
        end
    end

    // Phase timer restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (state_nx != state) begin
            tmr <= '0;
        end else if ((state == SETTLE) || (state == MEASURE)) begin
            tmr <= tmr + 1'b1;
        end
    end

    assign settle_end = (state == SETTLE)  && (tmr == SETTLE_LAST);
    assign gate_end   = (state == MEASURE) && (tmr == GATE_LAST);
    assign meas_entry = (state_nx == MEASURE) && (state != MEASURE);
    assign done_entry = (state_nx == DONE) && (state != DONE);

    // ro_clk_in is asynchronous: two sync flops plus history for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= ro_clk_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

    always_comb begin
        wcnt_nx = wcnt;
        wovf_nx = wovf;
        if ((state == MEASURE) && rise) begin
            if (wcnt == CNT_MAX) begin
                wovf_nx = 1'b1;
            end else begin
                wcnt_nx = wcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            wovf <= 1'b0;
        end else if (meas_entry) begin
            wcnt <= '0;
            wovf <= 1'b0;
        end else begin
            wcnt <= wcnt_nx;
            wovf <= wovf_nx;
        end
    end

`ifdef RO_FREQ_AVG_EN

    logic [1:0]       pass;
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] sum_add;
    logic             ovf_acc;
    logic             pass_end;
    logic             run_entry;

    assign last_pass = (pass == 2'd3);
    assign pass_end  = gate_end && !abort;
    assign run_entry = (state == IDLE) && (state_nx == SETTLE);
    assign sum_add   = sum + {2'b00, wcnt_nx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass    <= '0;
            sum     <= '0;
            ovf_acc <= 1'b0;
        end else if (run_entry) begin
            pass    <= '0;
            sum     <= '0;
            ovf_acc <= 1'b0;
        end else if (pass_end) begin
            pass    <= pass + 1'b1;
            sum     <= sum_add;
            ovf_acc <= ovf_acc | wovf_nx;
        end
    end

    // Divide the four-pass sum by four on publish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (done_entry) begin
            count    <= CNT_W'(sum_add >> 2);
            overflow <= ovf_acc | wovf_nx;
        end
    end

`else

    assign last_pass = 1'b1;

    // Include any edge seen on the final gate cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (done_entry) begin
            count    <= wcnt_nx;
            overflow <= wovf_nx;
        end
    end

`endif

endmodule

// File: doc/ro_freq_meter.md
RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning the number of clk cycles the oscillator is enabled before counting starts (minimum 1).
REQ-002 SHALL have parameter GATE_CYCLES, default 16, meaning the measurement window length in clk cycles (minimum 1).
REQ-003 SHALL have parameter CNT_W, default 8, meaning the width of the edge count result.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a measurement; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: cancel an in-progress measurement.
REQ-008 SHALL have port ro_clk_in, input, 1 bit: the ring oscillator clk_out, asynchronous to clk.
REQ-009 SHALL have port ro_en, output, 1 bit: drives the ring oscillator en input.
REQ-010 SHALL have port busy, output, 1 bit: high in SETTLE, MEASURE and DONE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a result is published.
REQ-012 SHALL have port count, output, CNT_W bits: last published edge count.
REQ-013 SHALL have port overflow, output, 1 bit: last published result saturated.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETTLE, MEASURE and DONE.
REQ-015 IDLE with start=1 SHALL go to SETTLE on the next edge; otherwise it SHALL stay in IDLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to MEASURE.
REQ-017 MEASURE SHALL last exactly GATE_CYCLES cycles, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-019 ro_en SHALL be registered and high exactly while the state is SETTLE or MEASURE.
REQ-020 ro_clk_in SHALL pass through a 2-flop synchronizer followed by one history flop; a rising edge is synchronized current=1 and history=0.
REQ-021 The working counter SHALL clear on entry to MEASURE and increment on each detected rising edge during MEASURE cycles only.
REQ-022 The working counter SHALL saturate at 2^CNT_W-1; an edge detected while saturated SHALL set the working overflow flag.
REQ-023 On entry to DONE, count and overflow SHALL update from the working values; done SHALL be high for that DONE cycle only.
REQ-024 count and overflow SHALL hold their values at all other times.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 abort=1 in SETTLE or MEASURE SHALL force IDLE on the next edge with ro_en low; it SHALL not pulse done or change count or overflow.
REQ-027 abort SHALL take priority over any SETTLE-to-MEASURE or MEASURE-to-DONE transition in the same cycle.
REQ-028 abort SHALL have no effect in IDLE or DONE.
REQ-029 Latency: if start is sampled on edge 0, done SHALL be high in cycle SETTLE_CYCLES+GATE_CYCLES+1.

Reset
REQ-030 rst=1 SHALL asynchronously force state IDLE and clear ro_en, busy, done, count, overflow, the working counter and all synchronizer and history flops.
REQ-031 rst asserted mid-measurement SHALL drop ro_en immediately; no done SHALL follow.

Configuration
REQ-032 With macro RO_FREQ_AVG_EN defined, one start SHALL run 4 back-to-back SETTLE+MEASURE passes and accumulate the edges in a CNT_W+2-bit sum.
REQ-033 With RO_FREQ_AVG_EN defined, count SHALL be the sum shifted right by 2, overflow SHALL be the OR of the per-pass overflow flags, and done SHALL pulse once at the end.
REQ-034 Without RO_FREQ_AVG_EN, the block SHALL perform a single pass as in REQ-014 to REQ-029.

Verification (SETTLE_CYCLES=4, GATE_CYCLES=16, CNT_W=8 unless stated)
REQ-035 ro_clk_in toggling every 2 clk cycles (period 4) with a start pulse -> done in cycle 21, count=4, overflow=0.
REQ-036 ro_clk_in held at 0 -> count=0, overflow=0, ro_en high for exactly 20 cycles.
REQ-037 CNT_W=3, ro_clk_in toggling every clk cycle (8 edges in the window) -> count=7, overflow=1.
REQ-038 abort in the 5th MEASURE cycle after a prior result of 4 -> ro_en low next cycle, no done, count still 4.
REQ-039 start held high continuously -> back-to-back measurements, each separated by one IDLE cycle, one done per measurement.
REQ-040 rst pulse mid-SETTLE -> ro_en=0 immediately, count=0; the next start gives a normal result.
